axis_frame_checker: RTL and testbench

Synthesizable AXI-Stream sink for the DMA MM2S output (`M_AXIS_MM2S_*`) of `top_bd_wrapper`. It closes the S2MM→memory→MM2S loop by checking every returned beat against the pattern produced by the stream stimulus, `{FIXED_DATA, beat_index}`. It also checks frame length, applies programmable backpressure, and reports pass/fail plus frame and error counts to the bench or to an AXI-Lite status register.

---
 rtl/axis_frame_checker_pkg.sv | 22 ++
 rtl/axis_frame_checker_if.sv | 13 +
 rtl/axis_frame_checker_bp_gen.sv | 38 +++
 rtl/axis_frame_checker.sv | 158 +++++++++++++++
 tb/tb_axis_frame_checker.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_frame_checker_pkg.sv
// Shared types and helpers for the AXI-Stream frame checker.
// Holds the FSM state encoding, the "no error" marker and the expected-word builder.
package axis_chk_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } chk_state_t;

  localparam logic [15:0] ERR_NONE = 16'hFFFF;

  // Expected beat: fixed prefix above a beat index that wraps at 2^cntr_w.
  function automatic logic [63:0] exp_word(input logic [63:0] fixed,
                                           input logic [15:0] idx,
                                           input int unsigned cntr_w);
    logic [63:0] mask;
    mask = (64'd1 << cntr_w) - 64'd1;
    return (fixed << cntr_w) | ({48'd0, idx} & mask);
  endfunction

endpackage

// File: rtl/axis_frame_checker_if.sv
// AXI-Stream channel between the returning DMA stream and the frame checker.
interface axis_frame_checker_if #(
  parameter int DATA_WIDTH = 32
) ();
  logic [DATA_WIDTH-1:0]   tdata;
  logic [DATA_WIDTH/8-1:0] tkeep;
  logic                    tlast;
  logic                    tvalid;
  logic                    tready;

  modport master (output tdata, output tkeep, output tlast, output tvalid, input tready);
  modport slave  (input tdata, input tkeep, input tlast, input tvalid, output tready);
endinterface

// File: rtl/axis_frame_checker_bp_gen.sv
// Backpressure generator: requests a one-cycle tready drop after every
// STALL_PERIOD accepted beats while the checker is running.
module axis_bp_gen #(
  parameter int STALL_PERIOD = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic run_i,
  input  logic accept_i,
  output logic ready_en_o
);

  localparam logic [15:0] LAST_CNT = (STALL_PERIOD > 0) ? 16'(STALL_PERIOD - 1) : 16'hFFFF;

  logic [15:0] cnt_q, cnt_d;
  logic        stall;

  always_comb begin
    stall = (STALL_PERIOD > 0) && accept_i && (cnt_q == LAST_CNT);
    cnt_d = cnt_q;
    if (!run_i || stall) begin
      cnt_d = 16'd0;
    end else if (accept_i) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  assign ready_en_o = !stall;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/axis_frame_checker.sv
// AXI-Stream sink that checks returned DMA frames against the {FIXED_DATA, beat_index}
// pattern, counts frames and errors, and reports pass/fail once NUM_FRAMES have arrived.
module axis_frame_checker
  import axis_chk_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int FRAME_LENGTH = 16,
  parameter int CNTR_WIDTH   = 4,
  parameter logic [DATA_WIDTH-CNTR_WIDTH-1:0] FIXED_DATA = 28'h666A500,
  parameter int NUM_FRAMES   = 1,
  parameter int STALL_PERIOD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  axis_frame_checker_if.slave  S_AXIS,
  output logic                 done,
  output logic                 pass,
  output logic [15:0]          frame_cnt,
  output logic [15:0]          err_cnt,
  output logic                 err_data,
  output logic                 err_len,
  output logic [15:0]          first_err_beat
);

  localparam logic [15:0] LAST_IDX    = 16'(FRAME_LENGTH - 1);
  localparam logic [15:0] FRAMES_GOAL = 16'(NUM_FRAMES);

  chk_state_t  state_q, state_d;
  logic        tready_q, tready_d;
  logic        done_q, done_d;
  logic        pass_q, pass_d;
  logic [15:0] bidx_q, bidx_d;
  logic [15:0] gbeat_q, gbeat_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;
  logic        err_data_q, err_data_d;
  logic        err_len_q, err_len_d;
  logic [15:0] first_err_q, first_err_d;

  logic        hs;
  logic        bp_ready;
  logic        data_bad;
  logic        len_bad;
  logic [16:0] err_sum;

  assign hs = S_AXIS.tvalid && tready_q;

  axis_bp_gen #(
    .STALL_PERIOD (STALL_PERIOD)
  ) u_bp_gen (
    .clk        (clk),
    .rst        (rst),
    .run_i      (state_q == RUN),
    .accept_i   (hs),
    .ready_en_o (bp_ready)
  );

  always_comb begin
    state_d     = state_q;
    done_d      = done_q;
    pass_d      = pass_q;
    bidx_d      = bidx_q;
    gbeat_d     = gbeat_q;
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    err_data_d  = err_data_q;
    err_len_d   = err_len_q;
    first_err_d = first_err_q;

    data_bad = (64'(S_AXIS.tdata) != exp_word(64'(FIXED_DATA), bidx_q, CNTR_WIDTH)) ||
               (S_AXIS.tkeep != '1);
    // Early tlast and a missing tlast at the last expected index are both length errors.
    len_bad  = S_AXIS.tlast ? (bidx_q < LAST_IDX) : (bidx_q == LAST_IDX);
    err_sum  = {1'b0, err_cnt_q} + 17'(data_bad) + 17'(len_bad);

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d     = RUN;
          done_d      = 1'b0;
          pass_d      = 1'b0;
          bidx_d      = 16'd0;
          gbeat_d     = 16'd0;
          frame_cnt_d = 16'd0;
          err_cnt_d   = 16'd0;
          err_data_d  = 1'b0;
          err_len_d   = 1'b0;
          first_err_d = ERR_NONE;
        end
      end
      RUN: begin
        if (hs) begin
          gbeat_d = (gbeat_q == 16'hFFFF) ? gbeat_q : gbeat_q + 16'd1;
          if (data_bad) err_data_d = 1'b1;
          if (len_bad)  err_len_d  = 1'b1;
          err_cnt_d = err_sum[16] ? 16'hFFFF : err_sum[15:0];
          if ((data_bad || len_bad) && !err_data_q && !err_len_q) begin
            first_err_d = gbeat_q;
          end
          if (S_AXIS.tlast) begin
            bidx_d      = 16'd0;
            frame_cnt_d = frame_cnt_q + 16'd1;
            if (frame_cnt_d == FRAMES_GOAL) begin
              state_d = DONE;
              done_d  = 1'b1;
              pass_d  = (err_cnt_d == 16'd0);
            end
          end else begin
            bidx_d = (bidx_q == 16'hFFFF) ? bidx_q : bidx_q + 16'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered tready follows the next state so it drops with the final tlast.
    tready_d = (state_d == RUN) && bp_ready;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      tready_q    <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      bidx_q      <= 16'd0;
      gbeat_q     <= 16'd0;
      frame_cnt_q <= 16'd0;
      err_cnt_q   <= 16'd0;
      err_data_q  <= 1'b0;
      err_len_q   <= 1'b0;
      first_err_q <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      tready_q    <= tready_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      bidx_q      <= bidx_d;
      gbeat_q     <= gbeat_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
      err_data_q  <= err_data_d;
      err_len_q   <= err_len_d;
      first_err_q <= first_err_d;
    end
  end

  assign S_AXIS.tready  = tready_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign frame_cnt      = frame_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_data       = err_data_q;
  assign err_len        = err_len_q;
  assign first_err_beat = first_err_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Scoreboard bench for axis_frame_checker: two instances (1 frame / no stall and
// 2 frames / stall every 4) share one stream driver; a monitor checks each finished run.
module tb_axis_frame_checker;

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic pass;
    int   frames;
    int   errs;
    logic ed;
    logic el;
    int   first;
    int   stalls;
    int   beats;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_a, start_b, sel;
  logic [31:0] tdata;
  logic [3:0]  tkeep;
  logic        tlast, tvalid;

  axis_frame_checker_if #(.DATA_WIDTH(32)) if_a ();
  axis_frame_checker_if #(.DATA_WIDTH(32)) if_b ();

  assign if_a.tdata  = tdata;
  assign if_a.tkeep  = tkeep;
  assign if_a.tlast  = tlast;
  assign if_a.tvalid = tvalid;
  assign if_b.tdata  = tdata;
  assign if_b.tkeep  = tkeep;
  assign if_b.tlast  = tlast;
  assign if_b.tvalid = tvalid;

  logic        done_a, pass_a, ed_a, el_a, done_b, pass_b, ed_b, el_b;
  logic [15:0] fc_a, ec_a, fe_a, fc_b, ec_b, fe_b;

  axis_frame_checker #(.NUM_FRAMES(1), .STALL_PERIOD(0)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .S_AXIS(if_a.slave),
    .done(done_a), .pass(pass_a), .frame_cnt(fc_a), .err_cnt(ec_a),
    .err_data(ed_a), .err_len(el_a), .first_err_beat(fe_a)
  );

  axis_frame_checker #(.NUM_FRAMES(2), .STALL_PERIOD(4)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .S_AXIS(if_b.slave),
    .done(done_b), .pass(pass_b), .frame_cnt(fc_b), .err_cnt(ec_b),
    .err_data(ed_b), .err_len(el_b), .first_err_beat(fe_b)
  );

  logic        d_tready, d_done, d_pass, d_ed, d_el;
  logic [15:0] d_fc, d_ec, d_fe;
  assign d_tready = sel ? if_b.tready : if_a.tready;
  assign d_done   = sel ? done_b : done_a;
  assign d_pass   = sel ? pass_b : pass_a;
  assign d_ed     = sel ? ed_b : ed_a;
  assign d_el     = sel ? el_b : el_a;
  assign d_fc     = sel ? fc_b : fc_a;
  assign d_ec     = sel ? ec_b : ec_a;
  assign d_fe     = sel ? fe_b : fe_a;

  int    n_pass = 0;
  int    n_total = 0;
  int    mon_cnt = 0;
  int    stall_cnt, beat_cnt;
  bit    armed = 0;
  bit    first_cyc = 0;
  beat_t stim_q[$];
  exp_t  exp_q[$];
  exp_t  me;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  // Reference model: walks the issued beat list using the frame rules directly.
  function automatic exp_t model(input int period);
    exp_t        e;
    int          idx;
    logic        any, d, l;
    logic [31:0] want;
    e.frames = 0; e.errs = 0; e.ed = 0; e.el = 0; e.first = 'hFFFF;
    idx = 0; any = 0;
    for (int g = 0; g < stim_q.size(); g++) begin
      want = (32'h0666A500 << 4) | 32'(idx % 16);
      d = (stim_q[g].data != want) || (stim_q[g].keep != 4'hF);
      l = stim_q[g].last ? (idx < 15) : (idx == 15);
      e.errs = e.errs + int'(d) + int'(l);
      if (e.errs > 65535) e.errs = 65535;
      if ((d || l) && !any) e.first = g;
      any  = any | d | l;
      e.ed = e.ed | d;
      e.el = e.el | l;
      if (stim_q[g].last) begin
        e.frames++;
        idx = 0;
      end else begin
        idx++;
      end
    end
    e.pass   = (e.errs == 0);
    e.beats  = stim_q.size();
    e.stalls = (period == 0) ? 0 : (e.beats - 1) / period;
    return e;
  endfunction

  task automatic add_frame(input int len);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = (32'h0666A500 << 4) | 32'(i % 16);
      b.keep = 4'hF;
      b.last = (i == len - 1);
      stim_q.push_back(b);
    end
  endtask

  task automatic do_start(input logic use_b);
    if (use_b) start_b = 1'b1;
    else       start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
    stall_cnt = 0;
    beat_cnt  = 0;
    first_cyc = 1;
    armed     = 1;
  endtask

  task automatic send_beats(input bit gaps);
    bit got;
    for (int i = 0; i < stim_q.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        tvalid = 1'b0;
        repeat ($urandom_range(1, 2)) @(posedge clk);
        #1;
      end
      tdata  = stim_q[i].data;
      tkeep  = stim_q[i].keep;
      tlast  = stim_q[i].last;
      tvalid = 1'b1;
      got = 0;
      for (int w = 0; w < 64 && !got; w++) begin
        @(negedge clk);
        if (d_tready) got = 1;
      end
      if (!got) begin
        check("beat_accept_timeout", 32'(d_tready), 32'd1);
        tvalid = 1'b0;
        tlast  = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic pulse_reset();
    rst   = 1'b1;
    armed = 0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_txn(input logic use_b);
    exp_t e;
    int   target;
    bit   got;
    sel = use_b;
    e = model(use_b ? 4 : 0);
    exp_q.push_back(e);
    target = mon_cnt + 1;
    do_start(use_b);
    send_beats(!use_b);
    got = 0;
    for (int w = 0; w < 40 && !got; w++) begin
      @(posedge clk);
      if (mon_cnt >= target) got = 1;
    end
    #1;
    if (!got) begin
      check("done_timeout", 32'(d_done), 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_back());
      pulse_reset();
    end
    stim_q.delete();
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_done"},      32'(d_done), 32'd0);
    check({tag, "_pass"},      32'(d_pass), 32'd0);
    check({tag, "_frame_cnt"}, 32'(d_fc),   32'd0);
    check({tag, "_err_cnt"},   32'(d_ec),   32'd0);
    check({tag, "_err_data"},  32'(d_ed),   32'd0);
    check({tag, "_err_len"},   32'(d_el),   32'd0);
    check({tag, "_first_err"}, 32'(d_fe),   32'hFFFF);
  endtask

  // Monitor: per-cycle tready/beat accounting, then scoreboard compare when done rises.
  always @(negedge clk) begin
    if (armed && !rst) begin
      if (d_done) begin
        if (exp_q.size() == 0) begin
          check("scoreboard_underflow", 32'(d_done), 32'd0);
        end else begin
          me = exp_q.pop_front();
          check("pass",           32'(d_pass), 32'(me.pass));
          check("frame_cnt",      32'(d_fc),   32'(me.frames));
          check("err_cnt",        32'(d_ec),   32'(me.errs));
          check("err_data",       32'(d_ed),   32'(me.ed));
          check("err_len",        32'(d_el),   32'(me.el));
          check("first_err_beat", 32'(d_fe),   32'(me.first));
          check("stall_cycles",   32'(stall_cnt), 32'(me.stalls));
          check("beats_accepted", 32'(beat_cnt),  32'(me.beats));
          check("tready_at_done", 32'(d_tready), 32'd0);
          $display("txn %0d dut=%0s beats=%0d frames=%0d err_cnt=%0d pass=%0d first_err=%0h stalls=%0d",
                   mon_cnt, sel ? "b" : "a", beat_cnt, d_fc, d_ec, d_pass, d_fe, stall_cnt);
        end
        armed = 0;
        mon_cnt++;
      end else begin
        if (first_cyc) check("tready_after_start", 32'(d_tready), 32'd1);
        first_cyc = 0;
        if (d_tready && tvalid) beat_cnt++;
        else if (!d_tready)     stall_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; sel = 1'b0;
    tdata = '0; tkeep = '0; tlast = 1'b0; tvalid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_cleared("reset_a");
    check("reset_tready_a", 32'(if_a.tready), 32'd0);
    check("reset_tready_b", 32'(if_b.tready), 32'd0);
    @(posedge clk); #1;

    // Clean frame, corrupt beat 5, early tlast at beat 9.
    add_frame(16);
    run_txn(1'b0);
    add_frame(16);
    stim_q[5].data = 32'h0666A5FF;
    run_txn(1'b0);
    add_frame(10);
    run_txn(1'b0);

    // Two-frame instance: early tlast, then a 20-beat frame with index wrap.
    add_frame(10);
    add_frame(20);
    run_txn(1'b1);
    add_frame(16);
    add_frame(16);
    run_txn(1'b1);

    // Reset in the middle of a frame, then a clean frame.
    sel = 1'b0;
    add_frame(16);
    while (stim_q.size() > 7) void'(stim_q.pop_back());
    do_start(1'b0);
    send_beats(1'b0);
    stim_q.delete();
    pulse_reset();
    @(negedge clk);
    check_cleared("midframe_rst");
    check("midframe_rst_tready", 32'(d_tready), 32'd0);
    @(posedge clk); #1;
    add_frame(16);
    run_txn(1'b0);

    // Bad tkeep on beat 0, then a re-start from DONE must clear everything.
    add_frame(16);
    stim_q[0].keep = 4'h7;
    run_txn(1'b0);
    start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    @(negedge clk);
    check_cleared("restart");
    check("restart_tready", 32'(d_tready), 32'd1);
    @(posedge clk); #1;
    add_frame(16);
    run_txn(1'b0);

    // Randomized frames with occasional length and data/keep errors.
    for (int t = 0; t < 24; t++) begin
      logic ub;
      int   nf, len;
      ub = 1'($urandom_range(0, 1));
      nf = ub ? 2 : 1;
      for (int f = 0; f < nf; f++) begin
        len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 24)) : 16;
        add_frame(len);
      end
      for (int i = 0; i < stim_q.size(); i++) begin
        if ($urandom_range(0, 15) == 0)
          stim_q[i].data = stim_q[i].data ^ (32'd1 << $urandom_range(0, 31));
        if ($urandom_range(0, 31) == 0)
          stim_q[i].keep = 4'($urandom_range(0, 14));
      end
      run_txn(ub);
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
